// File: rtl/au_absval_norm_seq.sv
// au_absval_norm_seq
// Sequential magnitude normalizer. It accepts one signed two's-complement word
// and forms its magnitude. It then left-shifts the magnitude one bit per clock
// until the MSB is 1. It returns the sign, the normalized magnitude, the shift
// count and a zero flag. Only one word is in flight at a time.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input word valid
//   in_ready   block can accept a word (IDLE only)
//   a          signed input word
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts result
//   sign       sign of the accepted word
//   mant       normalized magnitude
//   shift      number of left shifts applied
//   zero       accepted word was 0
module au_absval_norm_seq #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-1:0] mant,
    output logic [SW-1:0]    shift,
    output logic             zero
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic               r_sign;
    logic [WIDTH-1:0]   r_mant;
    logic [SW-1:0]      r_shift;
    logic               r_zero;
    logic [WIDTH-1:0]   w_abs;

    // The most negative input wraps to 100..0, which is its correct unsigned magnitude.
    assign w_abs = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    // Zero and already-normalized magnitudes need no shifting.
                    if (w_abs == '0 || w_abs[WIDTH-1]) begin
                        w_state_next = StDone;
                    end else begin
                        w_state_next = StShift;
                    end
                end
            end
            StShift: begin
                // The bit below the MSB reaches the MSB on this shift.
                if (r_mant[WIDTH-2]) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_mant  <= '0;
            r_shift <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sign  <= a[WIDTH-1];
                        r_mant  <= w_abs;
                        r_shift <= '0;
                        r_zero  <= (a == '0);
                    end
                end
                StShift: begin
                    r_mant  <= {r_mant[WIDTH-2:0], 1'b0};
                    r_shift <= r_shift + SW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sign      = r_sign;
    assign mant      = r_mant;
    assign shift     = r_shift;
    assign zero      = r_zero;

endmodule

// File: tb/tb_au_absval_norm_seq.sv
// Self-checking bench for au_absval_norm_seq (WIDTH=8): directed cases, back-to-back,
// reset mid-shift, then randomized words with random output stalls.
module tb_au_absval_norm_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic       sign;
    logic [7:0] mant;
    logic [2:0] shift;
    logic       zero;

    int n_checks;
    int n_fail;

    au_absval_norm_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sign     (sign),
        .mant     (mant),
        .shift    (shift),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: magnitude by integer arithmetic, then count doublings until it reaches 128.
    task automatic model(input logic [7:0] val, output int e_mag, output int e_k,
                         output logic [7:0] e_mant);
        int v;
        v = int'($signed(val));
        e_mag = (v < 0) ? -v : v;
        e_k = 0;
        if (e_mag != 0) begin
            while ((e_mag << e_k) < 128) e_k++;
        end
        e_mant = 8'((e_mag << e_k) & 255);
    endtask

    // Called at a negedge; waits for out_valid and returns the extra-cycle count.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_in_ready", in_ready, 0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input logic [7:0] val, input int lat, input string pfx);
        int e_mag, e_k;
        logic [7:0] e_mant;
        model(val, e_mag, e_k, e_mant);
        check({pfx, "_latency"}, lat, e_k);
        check({pfx, "_out_valid"}, out_valid, 1);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_sign"}, sign, (e_mag == 0) ? 0 : val[7]);
        check({pfx, "_mant"}, mant, e_mant);
        check({pfx, "_shift"}, shift, e_k);
        check({pfx, "_zero"}, zero, (val == 8'h00));
    endtask

    // Called at a negedge with the block in IDLE expected.
    task automatic run_word(input logic [7:0] val, input int stall);
        int w, lat;
        logic [7:0] m_hold;
        logic [2:0] s_hold;
        logic       sg_hold;
        in_valid  = 1'b1;
        a         = val;
        out_ready = (stall == 0);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        wait_valid(lat);
        check_result(val, lat, "word");
        m_hold  = mant;
        s_hold  = shift;
        sg_hold = sign;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_mant", mant, m_hold);
            check("stall_shift", shift, s_hold);
            check("stall_sign", sign, sg_hold);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {sign, mant, shift, zero}, 0);

        run_word(8'h01, 0);
        run_word(8'hF4, 0);
        run_word(8'hFF, 0);
        run_word(8'h80, 0);
        run_word(8'h00, 0);
        run_word(8'h05, 5);
        run_word(8'h7F, 1);

        // Reset mid-SHIFT: accept 0x01 at edge N, rst sampled at edge N+3.
        in_valid = 1'b1;
        a        = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", {sign, mant, shift, zero}, 0);
        run_word(8'h40, 0);

        // Back-to-back with in_valid and out_ready held high.
        in_valid  = 1'b1;
        a         = 8'h10;
        out_ready = 1'b1;
        @(negedge clk);
        wait_valid(lat);
        check_result(8'h10, lat, "b2b0");
        a = 8'hFE;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        wait_valid(lat);
        check_result(8'hFE, lat, "b2b1");
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle", in_ready, 1);

        for (int i = 0; i < 60; i++) begin
            run_word(8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
